// File: rtl/pipeir_queue.sv
// pipeir_queue: instruction queue between fetch and decode.
//   Buffers up to DEPTH fetched (pc4, instruction) pairs in a circular buffer
//   and presents the oldest to decode. A flush (taken branch/jump) discards
//   every buffered pair plus the one being offered in the same cycle.
// Ports:
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   f_valid/f_pc4/f_ins  : pair offered by fetch
//   f_ready              : queue accepts the offered pair this cycle
//   flush                : discard contents and the incoming pair
//   d_ready              : decode consumes the head this cycle
//   d_valid/d_pc4/d_ins  : head entry; all zero (a nop bubble) when not valid
//   count                : occupancy 0..DEPTH
//   drop_err             : sticky, fetch offered data while f_ready=0
module pipeir_queue #(
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     f_valid,
  input  logic [31:0]              f_pc4,
  input  logic [31:0]              f_ins,
  output logic                     f_ready,
  input  logic                     flush,
  input  logic                     d_ready,
  output logic                     d_valid,
  output logic [31:0]              d_pc4,
  output logic [31:0]              d_ins,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] ins;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rp, wp;
  logic            push, pop;
  entry_t          head;

  // Full queue refuses input even if decode pops this cycle: no path from
  // d_ready to f_ready.
  assign f_ready = ~reset & (count < CW'(DEPTH));
  assign d_valid = ~flush & (count != '0);
  assign push    = f_valid & f_ready & ~flush;
  assign pop     = d_valid & d_ready & ~flush;

  assign head  = mem[rp];
  assign d_pc4 = d_valid ? head.pc4 : 32'h0;
  assign d_ins = d_valid ? head.ins : 32'h0;

  // Payload storage is never cleared; only pointers/count define validity.
  always_ff @(posedge clock) begin
    if (push) mem[wp] <= '{pc4: f_pc4, ins: f_ins};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rp       <= '0;
      wp       <= '0;
      count    <= '0;
      drop_err <= 1'b0;
    end else if (flush) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else begin
      // Power-of-two DEPTH: pointer increment wraps naturally.
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (f_valid & ~f_ready) drop_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeir_queue.sv
module tb_pipeir_queue;
  localparam int DEPTH = 2;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset, f_valid, flush, d_ready;
  logic [31:0]   f_pc4, f_ins;
  logic          f_ready, d_valid, drop_err;
  logic [31:0]   d_pc4, d_ins;
  logic [CW-1:0] count;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: a plain queue of {pc4, ins} plus sticky error flag.
  logic [63:0] mq[$];
  logic        m_drop = 1'b0;

  pipeir_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .f_valid(f_valid), .f_pc4(f_pc4),
    .f_ins(f_ins), .f_ready(f_ready), .flush(flush), .d_ready(d_ready),
    .d_valid(d_valid), .d_pc4(d_pc4), .d_ins(d_ins), .count(count),
    .drop_err(drop_err)
  );

  always #5 clock = ~clock;

  function automatic logic e_fready();
    return !reset && (mq.size() < DEPTH);
  endfunction
  function automatic logic e_dvalid();
    return !flush && (mq.size() != 0);
  endfunction
  function automatic logic [31:0] e_pc4();
    return e_dvalid() ? mq[0][63:32] : 32'h0;
  endfunction
  function automatic logic [31:0] e_ins();
    return e_dvalid() ? mq[0][31:0] : 32'h0;
  endfunction

  // Apply inputs at the negative edge and let combinational outputs settle.
  task automatic drive(input logic rst, input logic fl, input logic fv,
                       input logic dr, input logic [31:0] pc, input logic [31:0] ins);
    reset = rst; flush = fl; f_valid = fv; d_ready = dr; f_pc4 = pc; f_ins = ins;
    #1;
  endtask

  // Advance one clock; the model follows the queue rules at the edge.
  task automatic tick();
    logic can_push, do_pop;
    @(posedge clock);
    if (reset) begin
      mq.delete(); m_drop = 1'b0;
    end else if (flush) begin
      mq.delete();
    end else begin
      can_push = mq.size() < DEPTH;
      do_pop   = (mq.size() != 0) && d_ready;
      if (f_valid && !can_push) m_drop = 1'b1;
      if (do_pop) void'(mq.pop_front());
      if (f_valid && can_push) mq.push_back({f_pc4, f_ins});
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0); tick();
  endtask

  task automatic test_reset();
    drive(1, 0, 1, 0, 32'h44, 32'h55);
    n_chk++; if (f_ready !== 1'b0) begin n_fail++; $display("FAIL reset_fready_during act=%0b exp=0", f_ready); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_chk++; if (count !== '0) begin n_fail++; $display("FAIL reset_count act=%0d exp=0", count); end
    n_chk++; if (d_valid !== 1'b0 || d_ins !== 32'h0 || d_pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_head act=%0b/%h/%h exp=0/0/0", d_valid, d_pc4, d_ins); end
    n_chk++; if (f_ready !== 1'b1) begin n_fail++; $display("FAIL reset_fready act=%0b exp=1", f_ready); end
    n_chk++; if (drop_err !== 1'b0) begin n_fail++; $display("FAIL reset_drop act=%0b exp=0", drop_err); end
  endtask

  task automatic test_first_push();
    do_reset();
    drive(0, 0, 1, 0, 32'h04, 32'h20010005);
    n_chk++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL nofallthrough act=%0b exp=0", d_valid); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_chk++; if (d_valid !== 1'b1 || d_pc4 !== 32'h04 || d_ins !== 32'h20010005)
      begin n_fail++; $display("FAIL first_push act=%0b/%h/%h exp=1/00000004/20010005", d_valid, d_pc4, d_ins); end
    n_chk++; if (count !== CW'(1)) begin n_fail++; $display("FAIL first_count act=%0d exp=1", count); end
  endtask

  task automatic test_full_drop();
    do_reset();
    drive(0, 0, 1, 0, 32'h04, 32'hA); tick();
    drive(0, 0, 1, 0, 32'h08, 32'hB);
    n_chk++; if (drop_err !== 1'b0) begin n_fail++; $display("FAIL drop_early act=%0b exp=0", drop_err); end
    tick();
    drive(0, 0, 1, 0, 32'h0C, 32'hD);
    n_chk++; if (count !== CW'(2) || f_ready !== 1'b0) begin n_fail++; $display("FAIL full_state act=%0d/%0b exp=2/0", count, f_ready); end
    tick();
    drive(0, 0, 0, 1, 0, 0);
    n_chk++; if (drop_err !== 1'b1) begin n_fail++; $display("FAIL drop_set act=%0b exp=1", drop_err); end
    n_chk++; if (d_pc4 !== 32'h04 || d_ins !== 32'hA) begin n_fail++; $display("FAIL drop_head act=%h/%h exp=4/a", d_pc4, d_ins); end
    tick(); tick(); tick();
    drive(0, 0, 0, 0, 0, 0);
    n_chk++; if (drop_err !== 1'b1 || count !== '0) begin n_fail++; $display("FAIL drop_sticky act=%0b/%0d exp=1/0", drop_err, count); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 1, 32'(4 * (i + 1)), 32'(32'h100 + i));
      if (i > 0) begin
        n_chk++;
        if (d_valid !== 1'b1 || d_pc4 !== 32'(4 * i) || d_ins !== 32'(32'h100 + i - 1) || count !== CW'(1)) begin
          n_fail++; $display("FAIL stream[%0d] act=%0b/%h/%h/%0d exp=1/%h/%h/1", i, d_valid, d_pc4, d_ins, count, 4 * i, 32'h100 + i - 1);
        end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(0, 0, 1, 0, 32'h04, 32'h1); tick();
    drive(0, 0, 1, 0, 32'h08, 32'h2); tick();
    drive(0, 1, 1, 1, 32'h10, 32'hC);
    n_chk++; if (d_valid !== 1'b0 || d_ins !== 32'h0) begin n_fail++; $display("FAIL flush_bubble act=%0b/%h exp=0/0", d_valid, d_ins); end
    tick();
    drive(0, 0, 0, 1, 0, 0);
    n_chk++; if (count !== '0 || d_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty act=%0d/%0b exp=0/0", count, d_valid); end
    tick();
    drive(0, 0, 0, 1, 0, 0);
    n_chk++; if (d_valid !== 1'b0 || d_ins === 32'hC) begin n_fail++; $display("FAIL flush_discard act=%0b/%h exp=0/0", d_valid, d_ins); end
    // Queue works normally after a flush, from pointer 0.
    drive(0, 0, 1, 0, 32'h20, 32'hE); tick();
    drive(0, 0, 0, 0, 0, 0);
    n_chk++; if (d_valid !== 1'b1 || d_pc4 !== 32'h20 || d_ins !== 32'hE) begin n_fail++; $display("FAIL flush_after act=%0b/%h/%h exp=1/20/e", d_valid, d_pc4, d_ins); end
  endtask

  task automatic test_full_pop();
    do_reset();
    drive(0, 0, 1, 0, 32'h04, 32'h11); tick();
    drive(0, 0, 1, 0, 32'h08, 32'h22); tick();
    drive(0, 0, 1, 1, 32'h0C, 32'h33);
    n_chk++; if (f_ready !== 1'b0 || d_valid !== 1'b1) begin n_fail++; $display("FAIL fullpop_cycle act=%0b/%0b exp=0/1", f_ready, d_valid); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_chk++; if (count !== CW'(DEPTH - 1) || f_ready !== 1'b1) begin n_fail++; $display("FAIL fullpop_next act=%0d/%0b exp=%0d/1", count, f_ready, DEPTH - 1); end
    n_chk++; if (d_pc4 !== 32'h08 || d_ins !== 32'h22) begin n_fail++; $display("FAIL fullpop_head act=%h/%h exp=8/22", d_pc4, d_ins); end
    n_chk++; if (drop_err !== 1'b1) begin n_fail++; $display("FAIL fullpop_drop act=%0b exp=1", drop_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(0, 0, 1, 0, 32'h04, 32'h1); tick();
    drive(0, 0, 1, 0, 32'h08, 32'h2); tick();
    drive(0, 0, 1, 0, 32'h0C, 32'h3); tick();
    drive(1, 0, 1, 1, 32'h10, 32'h4); tick();
    drive(0, 0, 0, 0, 0, 0);
    n_chk++; if (count !== '0 || d_valid !== 1'b0 || d_ins !== 32'h0) begin n_fail++; $display("FAIL rstmid_empty act=%0d/%0b/%h exp=0/0/0", count, d_valid, d_ins); end
    n_chk++; if (drop_err !== 1'b0 || f_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_flags act=%0b/%0b exp=0/1", drop_err, f_ready); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
            $urandom, $urandom);
      n_chk++; if (f_ready !== e_fready()) begin n_fail++; $display("FAIL rnd_fready[%0d] act=%0b exp=%0b", i, f_ready, e_fready()); end
      n_chk++; if (d_valid !== e_dvalid()) begin n_fail++; $display("FAIL rnd_dvalid[%0d] act=%0b exp=%0b", i, d_valid, e_dvalid()); end
      n_chk++; if (d_pc4 !== e_pc4() || d_ins !== e_ins()) begin n_fail++; $display("FAIL rnd_head[%0d] act=%h/%h exp=%h/%h", i, d_pc4, d_ins, e_pc4(), e_ins()); end
      n_chk++; if (count !== CW'(mq.size())) begin n_fail++; $display("FAIL rnd_count[%0d] act=%0d exp=%0d", i, count, mq.size()); end
      n_chk++; if (drop_err !== m_drop) begin n_fail++; $display("FAIL rnd_drop[%0d] act=%0b exp=%0b", i, drop_err, m_drop); end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; f_valid = 1'b0; d_ready = 1'b0; f_pc4 = '0; f_ins = '0;
    @(negedge clock);
    test_reset();
    test_first_push();
    test_full_drop();
    test_stream();
    test_flush();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeir_queue.md
# pipeir_queue

Instruction queue between the fetch stage and the decode stage of the pipelined CPU. Accepts fetched (pc4, instruction) pairs from fetch under a valid/ready handshake, buffers up to DEPTH of them, and presents the oldest to decode under a second valid/ready handshake. It decouples fetch from decode stalls and discards all buffered instructions on a taken branch or jump. When no instruction is available, decode sees a bubble (instruction 32'h0).

## Interface
- DEPTH, 2, number of entries; power of two, 2..8
- clock  in  1  pipeline clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- f_valid  in  1  fetch presents a valid pair this cycle
- f_pc4  in  32  fetch's pc+4
- f_ins  in  32  fetched instruction word
- f_ready  out  1  queue accepts a pair this cycle
- flush  in  1  taken branch/jump resolved; discard contents and the incoming pair
- d_ready  in  1  decode consumes the head this cycle (0 = decode stalled)
- d_valid  out  1  head entry valid
- d_pc4  out  32  head pc+4
- d_ins  out  32  head instruction; 32'h0 when d_valid=0
- count  out  log2(DEPTH)+1  current occupancy, 0..DEPTH
- drop_err  out  1  sticky: fetch presented data while f_ready=0

## Operation
- Storage is a circular buffer with DEPTH entries, read pointer rp and write pointer wp (log2(DEPTH) bits each, wrapping modulo DEPTH), and a registered count.
- push = f_valid & f_ready & ~flush: writes {f_pc4, f_ins} at wp, then wp+1.
- pop = d_valid & d_ready & ~flush: advances rp by 1.
- count_next = count + push - pop. A simultaneous push and pop leaves count unchanged.
- f_ready = ~reset & (count < DEPTH). There is no combinational dependence on d_ready: a full queue refuses input even when decode pops in the same cycle.
- d_valid = ~flush & (count != 0). d_pc4 and d_ins show the head entry when d_valid=1; otherwise both are 32'h0.
- flush: on the next edge rp=wp=0 and count=0. The incoming pair is not stored. In the flush cycle, d_valid=0 and d_ins=0 combinationally, so decode sees a nop. flush overrides push and pop.
- drop_err: set on any edge where f_valid=1 & f_ready=0 & ~flush & ~reset. It stays set until reset.
- There is no fall-through path. An entry pushed into an empty queue is visible to decode on the following cycle.

## Timing
- Reset (synchronous, checked at clock edge): rp=0, wp=0, count=0, drop_err=0. Resulting outputs: d_valid=0, d_pc4=0, d_ins=0, f_ready=1 after the reset cycle. While reset=1, f_ready=0.
- Reset has priority over flush, push and pop. Reset mid-operation discards all entries within the same edge.
- Latency: push at edge N gives d_valid=1 with that entry after edge N (cycle N+1), if it is at the head.
- Throughput: one push and one pop per cycle sustained whenever 0 < count < DEPTH.
- Full (count=DEPTH): f_ready=0. A pop in that cycle makes f_ready=1 in the next cycle.
- Empty (count=0): d_valid=0. A push in that cycle makes d_valid=1 in the next cycle.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble and no reordering.
- Data ordering is strictly FIFO. Entry contents are not cleared on pop or flush; only pointers and count reset.

## Test plan
- Reset, then push pc4=0x04/ins=0x20010005 with d_ready=0 → next cycle: d_valid=1, d_pc4=0x04, d_ins=0x20010005, count=1.
- DEPTH=2, d_ready=0, push 0x04/0xA and 0x08/0xB → count=2, f_ready=0. A third f_valid then sets drop_err=1, which stays set until reset.
- Continuous push 0x04, 0x08, 0x0C, ... with d_ready=1 for 10 cycles → outputs appear in order one per cycle after 1-cycle latency, count stays 1, pointers wrap with no gaps.
- Queue holds 2 entries, assert flush with f_valid=1 (0x10/0xC) and d_ready=1 → flush cycle: d_valid=0, d_ins=0. Next cycle: count=0, and 0xC is never output.
- Full queue, push and pop in the same cycle → pop succeeds, push refused (f_ready=0), count=DEPTH-1, next cycle f_ready=1.
- Assert reset for one cycle while count=2 and f_valid=1 → next cycle: count=0, d_valid=0, d_ins=0, drop_err=0, f_ready=1.
